xbee_api_rx: RTL and testbench
==============================

XBEE_API_RX -- requirements
Module: xbee_api_rx

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, meaning the byte width of the UART data path.
REQ-002 SHALL provide parameter MAX_PAYLOAD, default 32, meaning the maximum number of frame-data bytes buffered per frame.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 1_000_000, meaning the maximum number of clk cycles allowed between in-frame bytes.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with ports named as the codebase does (clk, reset).
REQ-005 clk  input  1  100 MHz system clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 rx_data  input  DATA_WIDTH  byte from the UART receiver.
REQ-008 rx_valid  input  1  single-cycle strobe qualifying rx_data; there is no backpressure.
REQ-009 pl_data  output  DATA_WIDTH  payload byte.
REQ-010 pl_valid  output  1  pl_data is valid.
REQ-011 pl_ready  input  1  consumer accepts the byte when pl_valid and pl_ready are both high.
REQ-012 pl_last  output  1  marks the final payload byte of a frame.
REQ-013 frame_ok  output  1  one-cycle pulse when the checksum passes.
REQ-014 frame_err  output  1  one-cycle pulse when a frame is rejected.
REQ-015 err_code  output  2  reason for rejection, valid while frame_err is high: 01 checksum, 10 bad length, 11 timeout/abort.
REQ-016 overrun  output  1  sticky flag: a byte was dropped during DRAIN.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, LEN_MSB, LEN_LSB, DATA, CSUM and DRAIN.
REQ-019 IDLE SHALL discard all bytes except 0x7E, which SHALL move the FSM to LEN_MSB.
REQ-020 The length SHALL be {MSB,LSB} as 16 bits. A length of 0 or greater than MAX_PAYLOAD SHALL pulse frame_err with err_code=10 one cycle after the LSB strobe, and the FSM SHALL return to IDLE.
REQ-021 In DATA, each byte SHALL be written to the buffer and added to an 8-bit modulo-256 sum; after exactly length bytes the FSM SHALL move to CSUM.
REQ-022 In CSUM, if (sum + byte) mod 256 = 0xFF, frame_ok SHALL pulse and the FSM SHALL move to DRAIN. Otherwise frame_err SHALL pulse with err_code=01, the buffer SHALL be flushed and the FSM SHALL return to IDLE.
REQ-023 Latency: frame_ok and the first pl_valid SHALL both assert exactly 1 cycle after the checksum strobe.
REQ-024 DRAIN SHALL present buffered bytes in order, holding pl_data stable while pl_ready is low. pl_last SHALL be high on byte number length. The FSM SHALL return to IDLE in the cycle after the last byte is accepted.
REQ-025 No payload byte of a rejected frame SHALL ever appear on pl_valid (store-and-forward).
REQ-026 An rx_valid strobe during DRAIN SHALL be discarded and SHALL set overrun, including when the byte is 0x7E.
REQ-027 A timeout counter SHALL clear on every rx_valid. In LEN_MSB through CSUM, reaching TIMEOUT_CYCLES-1 SHALL pulse frame_err with err_code=11 and return the FSM to IDLE.
REQ-028 If a checksum-byte strobe and timeout expiry coincide, the byte SHALL win.

Reset
REQ-029 Reset SHALL force state=IDLE, pl_valid=0, pl_last=0, pl_data=0, frame_ok=0, frame_err=0, err_code=00, overrun=0, busy=0, sum=0, and both buffer pointers to 0.
REQ-030 Reset asserted mid-frame or mid-DRAIN SHALL discard the frame, and no partial output SHALL follow deassertion.

Configuration
REQ-031 With XBEE_API_ESCAPE_EN defined, the block SHALL implement API mode 2 escaping:
- 0x7D SHALL be dropped and the next byte XORed with 0x20 before the length, DATA and CSUM processing.
- An unescaped 0x7E in LEN_MSB through CSUM SHALL pulse frame_err with err_code=11 and restart at LEN_MSB.
REQ-032 Without XBEE_API_ESCAPE_EN, no unescaping SHALL occur, and 0x7E after IDLE SHALL be treated as ordinary data.

Structure
REQ-033 Package xbee_pkg SHALL hold the state enum, the constants API_DELIM=0x7E, API_ESC=0x7D and API_XOR=0x20, and the err_code localparams.
REQ-034 The payload buffer SHALL be a separate sub-module, xbee_frame_buf: MAX_PAYLOAD x DATA_WIDTH storage with write pointer, read pointer and flush.

Verification
REQ-035 Input 7E 00 03 41 42 43 39 -> frame_ok pulse, then pl_data 41,42,43 with pl_last on 43, and no frame_err.
REQ-036 Input 7E 00 03 41 42 43 38 -> frame_err with err_code=01, and pl_valid never rises.
REQ-037 Input 7E 00 21 with MAX_PAYLOAD=32 -> frame_err with err_code=10, busy=0 the next cycle, and a following good frame is accepted.
REQ-038 With TIMEOUT_CYCLES=100, input 7E 00 02 41 then silence -> frame_err with err_code=11 exactly 99 cycles after the 41 strobe.
REQ-039 With XBEE_API_ESCAPE_EN defined, input 7E 00 01 7D 5E 81 -> single byte pl_data=7E with pl_last=1. Without the macro, the same input -> frame_err with err_code=01.
REQ-040 Good frame with pl_ready held low for 5 cycles, an extra rx strobe injected, then reset asserted mid-DRAIN -> pl_data stable during the stall, overrun=1, all outputs cleared immediately on reset, and no output after release.

Source files
------------

// File: rtl/xbee_pkg.sv
// xbee_pkg: shared types and constants for the XBee API-frame receiver.
package xbee_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_MSB,
    ST_LEN_LSB,
    ST_DATA,
    ST_CSUM,
    ST_DRAIN
  } state_e;

  localparam logic [7:0] API_DELIM = 8'h7E;
  localparam logic [7:0] API_ESC   = 8'h7D;
  localparam logic [7:0] API_XOR   = 8'h20;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

endpackage

// File: rtl/xbee_api_rx_if.sv
// xbee_api_rx_if: UART byte input stream and payload output stream.
interface xbee_api_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] pl_data;
  logic                  pl_valid;
  logic                  pl_ready;
  logic                  pl_last;

  modport master (output rx_data, rx_valid, pl_ready, input pl_data, pl_valid, pl_last);
  modport slave  (input rx_data, rx_valid, pl_ready, output pl_data, pl_valid, pl_last);
endinterface

// File: rtl/xbee_frame_buf.sv
// xbee_frame_buf: store-and-forward payload buffer with write/read pointers and flush.
module xbee_frame_buf #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_PAYLOAD = 32,
  parameter int PTR_W       = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [PTR_W-1:0]      wr_ptr_o,
  output logic [PTR_W-1:0]      rd_ptr_o
);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  logic [DATA_WIDTH-1:0] mem_q [MAX_PAYLOAD];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;

  // Pointer update: flush wins over any write or read in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only observable through pointers, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_o  = wr_ptr_q;
  assign rd_ptr_o  = rd_ptr_q;
endmodule

// File: rtl/xbee_api_rx.sv
// xbee_api_rx: XBee API frame receiver. Parses 7E/len/data/checksum frames,
// buffers the payload and forwards it only after the checksum passes.
// Optional feature: define XBEE_API_ESCAPE_EN for API mode 2 byte escaping.
module xbee_api_rx
  import xbee_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_PAYLOAD    = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         reset,
  xbee_api_rx_if.slave bus,
  output logic         frame_ok,
  output logic         frame_err,
  output logic [1:0]   err_code,
  output logic         overrun,
  output logic         busy
);
  localparam int PW = $clog2(MAX_PAYLOAD + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]           MAX_LEN  = 16'(MAX_PAYLOAD);
  localparam logic [DATA_WIDTH-1:0] DELIM_W  = DATA_WIDTH'(API_DELIM);

  state_e          state_q, state_d;
  logic [7:0]      len_msb_q, len_msb_d;
  logic [PW-1:0]   len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            ok_q, ok_d, err_q, err_d, ovr_q, ovr_d;
  logic [1:0]      code_q, code_d;

  logic                  in_frame, byte_v, delim_abort;
  logic [DATA_WIDTH-1:0] byte_w;
  logic [7:0]            byte8, csum;
  logic [15:0]           len_full;
  logic                  buf_flush, buf_wr, buf_rd;
  logic [DATA_WIDTH-1:0] buf_rd_data;
  logic [PW-1:0]         wr_ptr, rd_ptr;

  assign in_frame = (state_q inside {ST_LEN_MSB, ST_LEN_LSB, ST_DATA, ST_CSUM});
  assign byte8    = byte_w[7:0];

`ifdef XBEE_API_ESCAPE_EN
  localparam logic [DATA_WIDTH-1:0] ESC_W = DATA_WIDTH'(API_ESC);
  localparam logic [DATA_WIDTH-1:0] XOR_W = DATA_WIDTH'(API_XOR);
  logic esc_q, esc_d;

  // Escape-pending flag: set by 0x7D, consumed by the following byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) esc_q <= 1'b0;
    else       esc_q <= esc_d;
  end

  // Strip escapes and spot a raw delimiter inside a frame.
  always_comb begin
    esc_d       = esc_q;
    byte_v      = 1'b0;
    byte_w      = bus.rx_data;
    delim_abort = 1'b0;
    if (!in_frame) begin
      esc_d = 1'b0;
    end else if (bus.rx_valid) begin
      if (bus.rx_data == DELIM_W) begin
        delim_abort = 1'b1;
        esc_d       = 1'b0;
      end else if (esc_q) begin
        byte_v = 1'b1;
        byte_w = bus.rx_data ^ XOR_W;
        esc_d  = 1'b0;
      end else if (bus.rx_data == ESC_W) begin
        esc_d = 1'b1;
      end else begin
        byte_v = 1'b1;
      end
    end
  end
`else
  // Raw byte path: every in-frame byte is data, 0x7E included.
  always_comb begin
    byte_v      = bus.rx_valid && in_frame;
    byte_w      = bus.rx_data;
    delim_abort = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state, buffer control and status-pulse decode.
  always_comb begin
    state_d   = state_q;
    len_msb_d = len_msb_q;
    len_d     = len_q;
    sum_d     = sum_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = ERR_NONE;
    ovr_d     = ovr_q;
    buf_flush = 1'b0;
    buf_wr    = 1'b0;
    buf_rd    = 1'b0;
    len_full  = {len_msb_q, byte8};
    csum      = sum_q + byte8;
    tmo_d     = (bus.rx_valid || !in_frame) ? '0 : tmo_q + TW'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid && bus.rx_data == DELIM_W) begin
          state_d   = ST_LEN_MSB;
          sum_d     = '0;
          buf_flush = 1'b1;
        end
      end
      ST_LEN_MSB: begin
        if (byte_v) begin
          len_msb_d = byte8;
          state_d   = ST_LEN_LSB;
        end
      end
      ST_LEN_LSB: begin
        if (byte_v) begin
          if (len_full == 16'd0 || len_full > MAX_LEN) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = ST_IDLE;
          end else begin
            len_d   = PW'(len_full);
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (byte_v) begin
          buf_wr = 1'b1;
          sum_d  = sum_q + byte8;
          if (wr_ptr == len_q - PW'(1)) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (byte_v) begin
          if (csum == 8'hFF) begin
            ok_d    = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            err_d     = 1'b1;
            code_d    = ERR_CSUM;
            state_d   = ST_IDLE;
            buf_flush = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (bus.rx_valid) ovr_d = 1'b1;
        if (bus.pl_ready) begin
          buf_rd = 1'b1;
          if (rd_ptr == len_q - PW'(1)) begin
            state_d   = ST_IDLE;
            buf_flush = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A raw delimiter restarts the frame; silence returns to IDLE.
    // An arriving byte always clears the counter, so it beats expiry.
    if (delim_abort) begin
      err_d     = 1'b1;
      code_d    = ERR_TMO;
      state_d   = ST_LEN_MSB;
      sum_d     = '0;
      buf_flush = 1'b1;
    end else if (in_frame && !bus.rx_valid && tmo_d == TMO_LAST) begin
      err_d     = 1'b1;
      code_d    = ERR_TMO;
      state_d   = ST_IDLE;
      buf_flush = 1'b1;
    end
  end

  // Frame registers, timeout counter and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_msb_q <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      tmo_q     <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
      ovr_q     <= 1'b0;
    end else begin
      len_msb_q <= len_msb_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      tmo_q     <= tmo_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      code_q    <= code_d;
      ovr_q     <= ovr_d;
    end
  end

  xbee_frame_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_PAYLOAD(MAX_PAYLOAD),
    .PTR_W      (PW)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (buf_flush),
    .wr_en_i  (buf_wr),
    .wr_data_i(byte_w),
    .rd_en_i  (buf_rd),
    .rd_data_o(buf_rd_data),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr)
  );

  assign bus.pl_valid = (state_q == ST_DRAIN);
  assign bus.pl_data  = bus.pl_valid ? buf_rd_data : '0;
  assign bus.pl_last  = bus.pl_valid && (rd_ptr == len_q - PW'(1));
  assign frame_ok     = ok_q;
  assign frame_err    = err_q;
  assign err_code     = code_q;
  assign overrun      = ovr_q;
  assign busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_xbee_api_rx.sv
// tb_xbee_api_rx: directed bench for xbee_api_rx with a frame-level reference model.
// Honours XBEE_API_ESCAPE_EN the same way the design does.
module tb_xbee_api_rx;
  localparam int MAXP = 32;

  typedef logic [7:0] bq_t[$];
  typedef struct packed { logic [7:0] d; logic l; } pl_t;

  logic       clk, reset;
  logic       frame_ok, frame_err, overrun, busy;
  logic [1:0] err_code;

  xbee_api_rx_if #(.DATA_WIDTH(8)) bus ();

  xbee_api_rx #(.DATA_WIDTH(8), .MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(100)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         n_cmp = 0;
  int         n_fail = 0;
  pl_t        exp_pl[$];
  logic [1:0] exp_err[$];
  int         exp_ok = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level reference: scan a byte stream and queue the expected outcomes.
  function automatic void model_stream(input bq_t s);
    int         i, len;
    bit         done;
    bq_t        body;
    logic [7:0] sum;
    i = 0;
    len = 0;
    while (i < s.size()) begin
      if (s[i] != 8'h7E) begin
        i++;
        continue;
      end
      i++;
      body.delete();
      done = 0;
      while (i < s.size() && !done) begin
`ifdef XBEE_API_ESCAPE_EN
        if (s[i] == 8'h7E) break;
        if (s[i] == 8'h7D) begin
          if (i + 1 >= s.size()) begin i++; break; end
          if (s[i+1] == 8'h7E) begin i++; break; end
          body.push_back(s[i+1] ^ 8'h20);
          i += 2;
        end else begin
          body.push_back(s[i]);
          i++;
        end
`else
        body.push_back(s[i]);
        i++;
`endif
        if (body.size() >= 2) begin
          len = int'({body[0], body[1]});
          if (len == 0 || len > MAXP) done = 1;
          else if (body.size() == len + 3) done = 1;
        end
      end
      if (done) begin
        if (len == 0 || len > MAXP) exp_err.push_back(2'b10);
        else begin
          sum = 8'h00;
          for (int k = 0; k < len + 1; k++) sum += body[2+k];
          if (sum == 8'hFF) begin
            exp_ok++;
            for (int k = 0; k < len; k++) exp_pl.push_back({body[2+k], k == len - 1});
          end else exp_err.push_back(2'b01);
        end
      end else if (i < s.size()) exp_err.push_back(2'b11);
    end
  endfunction

  function automatic bq_t make_frame(input bq_t p);
    bq_t        f;
    logic [7:0] sum;
    sum = 8'h00;
    f.push_back(8'h7E);
    f.push_back(8'(p.size() >> 8));
    f.push_back(8'(p.size()));
    foreach (p[k]) begin
      f.push_back(p[k]);
      sum += p[k];
    end
    f.push_back(8'hFF - sum);
    return f;
  endfunction

  // Single-cycle strobe; entered and left just after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input bq_t s);
    foreach (s[k]) send_byte(s[k]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cycle-by-cycle comparison of the output streams against the model queues.
  always @(negedge clk) begin : cmp
    pl_t e;
    if (bus.pl_valid && bus.pl_ready) begin
      if (exp_pl.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pl_unexpected: got byte %0h, no byte expected at %0t", bus.pl_data, $time);
      end else begin
        e = exp_pl.pop_front();
        check("pl_data", 32'(bus.pl_data), 32'(e.d));
        check("pl_last", 32'(bus.pl_last), 32'(e.l));
      end
    end
    if (frame_err) begin
      if (exp_err.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL err_unexpected: got code %0d, no error expected at %0t", err_code, $time);
      end else check("err_code", 32'(err_code), 32'(exp_err.pop_front()));
    end
    if (frame_ok) begin
      n_cmp++;
      if (exp_ok == 0) begin
        n_fail++;
        $display("FAIL ok_unexpected: got frame_ok=1, want 0 at %0t", $time);
      end else exp_ok--;
    end
  end

  initial begin
    bq_t q, p;
    bit  seen;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.pl_ready = 1'b1;
    reset        = 1'b1;

    // Reset state
    #1;
    check("rst_pl_valid", 32'(bus.pl_valid), 0);
    check("rst_pl_last",  32'(bus.pl_last),  0);
    check("rst_pl_data",  32'(bus.pl_data),  0);
    check("rst_ok",       32'(frame_ok),     0);
    check("rst_err",      32'(frame_err),    0);
    check("rst_code",     32'(err_code),     0);
    check("rst_overrun",  32'(overrun),      0);
    check("rst_busy",     32'(busy),         0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Good frame 41 42 43
    q = make_frame({8'h41, 8'h42, 8'h43});
    check("mk_csum", 32'(q[6]), 32'h39);
    model_stream(q);
    check("m_good_n",    32'(exp_pl.size()), 3);
    check("m_good_last", 32'(exp_pl[2]), 32'({8'h43, 1'b1}));
    send_bytes(q);
    @(negedge clk);
    check("good_ok",   32'(frame_ok),     1);
    check("good_vld",  32'(bus.pl_valid), 1);
    check("good_d0",   32'(bus.pl_data),  32'h41);
    check("good_l0",   32'(bus.pl_last),  0);
    check("good_err",  32'(frame_err),    0);
    @(negedge clk);
    check("good_d1",   32'(bus.pl_data),  32'h42);
    @(negedge clk);
    check("good_d2",   32'(bus.pl_data),  32'h43);
    check("good_l2",   32'(bus.pl_last),  1);
    @(negedge clk);
    check("good_idle", 32'(busy),         0);
    check("good_done", 32'(bus.pl_valid), 0);
    idle(3);

    // Bad checksum
    q = {8'h7E, 8'h00, 8'h03, 8'h41, 8'h42, 8'h43, 8'h38};
    model_stream(q);
    check("m_bad_err", 32'(exp_err.size()), 1);
    send_bytes(q);
    @(negedge clk);
    check("bad_err",  32'(frame_err),    1);
    check("bad_code", 32'(err_code),     1);
    check("bad_vld",  32'(bus.pl_valid), 0);
    check("bad_busy", 32'(busy),         0);
    idle(5);

    // Length 33 > MAX_PAYLOAD, then length 0
    q = {8'h7E, 8'h00, 8'h21};
    model_stream(q);
    send_bytes(q);
    @(negedge clk);
    check("len33_err",  32'(frame_err), 1);
    check("len33_code", 32'(err_code),  2);
    check("len33_busy", 32'(busy),      0);
    @(negedge clk);
    check("len33_busy2", 32'(busy), 0);
    idle(2);
    q = {8'h7E, 8'h00, 8'h00};
    model_stream(q);
    send_bytes(q);
    @(negedge clk);
    check("len0_code", 32'(err_code), 2);
    idle(2);

    // Maximum length frame, then a short frame
    p.delete();
    for (int k = 0; k < MAXP; k++) p.push_back(8'(k));
    q = make_frame(p);
    check("mk_max_csum", 32'(q[MAXP+3]), 32'h0F);
    model_stream(q);
    send_bytes(q);
    idle(MAXP + 4);
    q = make_frame({8'h10, 8'h20});
    check("mk_short_csum", 32'(q[5]), 32'hCF);
    model_stream(q);
    send_bytes(q);
    idle(5);

    // Timeout: 99 edges after the last byte
    q = {8'h7E, 8'h00, 8'h02, 8'h41};
    model_stream(q);
    exp_err.push_back(2'b11);
    send_bytes(q);
    seen = 0;
    repeat (99) begin
      @(negedge clk);
      if (frame_err) seen = 1;
    end
    check("tmo_early", 32'(seen), 0);
    @(negedge clk);
    check("tmo_err",  32'(frame_err), 1);
    check("tmo_code", 32'(err_code),  3);
    check("tmo_busy", 32'(busy),      0);
    idle(3);

    // Checksum byte arriving on the expiry edge wins
    q = {8'h7E, 8'h00, 8'h01, 8'h55, 8'hAA};
    model_stream(q);
    send_byte(8'h7E);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h55);
    repeat (98) @(posedge clk);
    #1;
    send_byte(8'hAA);
    @(negedge clk);
    check("race_ok",  32'(frame_ok),  1);
    check("race_err", 32'(frame_err), 0);
    idle(4);

    // Escaped payload byte
    q = {8'h7E, 8'h00, 8'h01, 8'h7D, 8'h5E, 8'h81};
    model_stream(q);
`ifdef XBEE_API_ESCAPE_EN
    send_bytes(q);
    @(negedge clk);
    check("esc_ok",   32'(frame_ok),     1);
    check("esc_data", 32'(bus.pl_data),  32'h7E);
    check("esc_last", 32'(bus.pl_last),  1);
`else
    send_byte(8'h7E);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h7D);
    send_byte(8'h5E);
    @(negedge clk);
    check("noesc_err",  32'(frame_err), 1);
    check("noesc_code", 32'(err_code),  1);
    @(posedge clk);
    #1;
    send_byte(8'h81);
`endif
    idle(4);

    // Stall, overrun, then reset in the middle of the drain
    bus.pl_ready = 1'b0;
    q = make_frame({8'h11, 8'h22, 8'h33});
    model_stream(q);
    send_bytes(q);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_vld",  32'(bus.pl_valid), 1);
      check("stall_data", 32'(bus.pl_data),  32'h11);
      if (k == 2) send_byte(8'h7E);
      else begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    check("ovr_set",    32'(overrun),     1);
    check("ovr_data",   32'(bus.pl_data), 32'h11);
    check("ovr_busy",   32'(busy),        1);
    @(posedge clk);
    #1;
    bus.pl_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.pl_ready = 1'b0;
    @(negedge clk);
    check("drain_d1", 32'(bus.pl_data), 32'h22);
    check("drain_l1", 32'(bus.pl_last), 0);
    #2;
    exp_pl.delete();
    reset = 1'b1;
    #1;
    check("mid_rst_vld",  32'(bus.pl_valid), 0);
    check("mid_rst_data", 32'(bus.pl_data),  0);
    check("mid_rst_last", 32'(bus.pl_last),  0);
    check("mid_rst_ovr",  32'(overrun),      0);
    check("mid_rst_busy", 32'(busy),         0);
    check("mid_rst_ok",   32'(frame_ok),     0);
    check("mid_rst_err",  32'(frame_err),    0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.pl_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.pl_valid || frame_ok || frame_err || busy) seen = 1;
    end
    check("post_rst_quiet", 32'(seen), 0);

    check("left_pl",  32'(exp_pl.size()),  0);
    check("left_err", 32'(exp_err.size()), 0);
    check("left_ok",  32'(exp_ok),         0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
